maxi_full_burst_master: RTL and testbench

- AXI4-full burst master that drives the saxi_full_garin slave.
- On a start request it performs one INCR write burst of deterministic data, collects the write response, reads the same burst back and checks every beat.
- Reports completion and a sticky error flag.
- Replaces ad-hoc stimulus as the upstream AXI source for the slave, in simulation and on hardware.

---
 rtl/maxi_full_burst_master_if.sv | 80 ++++++++
 rtl/maxi_full_burst_master.sv | 208 ++++++++++++++++++++
 tb/tb_maxi_full_burst_master.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxi_full_burst_master_if.sv
// AXI4-full bus bundle between maxi_full_burst_master and its slave.
// Parameters : ID_WIDTH, ADDR_WIDTH, DATA_WIDTH (match the master's C_M_AXI_* values)
// Modports   : master - drives AW/W/AR payload+valid, BREADY, RREADY
//              slave  - drives AWREADY, WREADY, B channel, ARREADY, R channel
interface maxi_full_burst_master_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  // write address
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;
  // write data
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // write response
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // read address
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;
  // read data
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/maxi_full_burst_master.sv
// AXI4-full burst master: on a rising edge of INIT_AXI_TXN it writes one INCR
// burst of seed-based data (beat i = seed + i), collects the write response,
// reads the same burst back and checks every beat.
// Ports:
//   M_AXI_ACLK    - clock
//   M_AXI_ARESETN - synchronous active-low reset
//   INIT_AXI_TXN  - start request (0->1 edge, honoured in IDLE/DONE only)
//   TXN_DONE      - high while in DONE
//   ERROR         - sticky: BRESP/RRESP error, data miscompare or RLAST misplacement
//   m_axi         - AXI4-full master port (maxi_full_burst_master_if.master)
module maxi_full_burst_master #(
  parameter int          C_M_AXI_ID_WIDTH     = 1,
  parameter int          C_M_AXI_ADDR_WIDTH   = 6,
  parameter int          C_M_AXI_DATA_WIDTH   = 32,
  parameter int unsigned C_M_BURST_LEN        = 4,
  parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h0,
  parameter logic [31:0] C_M_DATA_SEED        = 32'h55
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      INIT_AXI_TXN,
  output logic                      TXN_DONE,
  output logic                      ERROR,
  maxi_full_burst_master_if.master  m_axi
);

  localparam int                          DW       = C_M_AXI_DATA_WIDTH;
  localparam logic [7:0]                  LAST_IDX = 8'(C_M_BURST_LEN - 1);
  localparam logic [2:0]                  SIZE     = 3'($clog2(DW / 8));
  localparam logic [DW-1:0]               SEED     = DW'(C_M_DATA_SEED);
  localparam logic [DW-1:0]               ONE      = DW'(1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE   = C_M_AXI_ADDR_WIDTH'(C_M_TARGET_BASE_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT_B,
    ST_READ,
    ST_DONE
  } state_t;

  state_t        state;
  logic          init_q;
  logic          awvalid_r;
  logic          wvalid_r;
  logic          wlast_r;
  logic [DW-1:0] wdata_r;
  logic          bready_r;
  logic          arvalid_r;
  logic          rready_r;
  logic          txn_done_r;
  logic          error_r;
  logic [7:0]    w_idx;
  logic [7:0]    r_idx;
  logic [DW-1:0] r_exp;
  logic          aw_done;
  logic          w_done;

  logic start;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;

  assign start = INIT_AXI_TXN && !init_q;
  assign aw_hs = awvalid_r && m_axi.awready;
  assign w_hs  = wvalid_r  && m_axi.wready;
  assign b_hs  = bready_r  && m_axi.bvalid;
  assign ar_hs = arvalid_r && m_axi.arready;
  assign r_hs  = rready_r  && m_axi.rvalid;

  // IDs are fixed at 0, so returned IDs and the low response bit carry nothing we act on.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, m_axi.bid, m_axi.rid, m_axi.bresp[0], m_axi.rresp[0]};

  // Static address/control fields
  assign m_axi.awid     = '0;
  assign m_axi.awaddr   = BASE;
  assign m_axi.awlen    = LAST_IDX;
  assign m_axi.awsize   = SIZE;
  assign m_axi.awburst  = 2'b01;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awcache  = 4'b0010;
  assign m_axi.awprot   = '0;
  assign m_axi.awqos    = '0;
  assign m_axi.awregion = '0;
  assign m_axi.wstrb    = '1;
  assign m_axi.arid     = '0;
  assign m_axi.araddr   = BASE;
  assign m_axi.arlen    = LAST_IDX;
  assign m_axi.arsize   = SIZE;
  assign m_axi.arburst  = 2'b01;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = 4'b0010;
  assign m_axi.arprot   = '0;
  assign m_axi.arqos    = '0;
  assign m_axi.arregion = '0;

  // Registered handshake outputs
  assign m_axi.awvalid = awvalid_r;
  assign m_axi.wdata   = wdata_r;
  assign m_axi.wlast   = wlast_r;
  assign m_axi.wvalid  = wvalid_r;
  assign m_axi.bready  = bready_r;
  assign m_axi.arvalid = arvalid_r;
  assign m_axi.rready  = rready_r;
  assign TXN_DONE      = txn_done_r;
  assign ERROR         = error_r;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state      <= ST_IDLE;
      init_q     <= 1'b0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      wlast_r    <= 1'b0;
      wdata_r    <= SEED;
      bready_r   <= 1'b0;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
      txn_done_r <= 1'b0;
      error_r    <= 1'b0;
      w_idx      <= '0;
      r_idx      <= '0;
      r_exp      <= SEED;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_WRITE;
            error_r    <= 1'b0;
            txn_done_r <= 1'b0;
            awvalid_r  <= 1'b1;
            wvalid_r   <= 1'b1;
            wlast_r    <= (LAST_IDX == 8'd0);
            wdata_r    <= SEED;
            w_idx      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
          end
        end

        ST_WRITE: begin
          if (aw_hs) begin
            awvalid_r <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wdata_r <= wdata_r + ONE;
            if (wlast_r) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              w_done   <= 1'b1;
            end else begin
              w_idx   <= w_idx + 8'd1;
              wlast_r <= ((w_idx + 8'd1) == LAST_IDX);
            end
          end
          // Address and data complete independently; leave once both are done,
          // including the case where the final handshakes land on this edge.
          if ((aw_done || aw_hs) && (w_done || (w_hs && wlast_r))) begin
            state    <= ST_WAIT_B;
            bready_r <= 1'b1;
          end
        end

        ST_WAIT_B: begin
          if (b_hs) begin
            if (m_axi.bresp[1]) error_r <= 1'b1;
            bready_r  <= 1'b0;
            state     <= ST_READ;
            arvalid_r <= 1'b1;
            rready_r  <= 1'b1;
            r_idx     <= '0;
            r_exp     <= SEED;
          end
        end

        ST_READ: begin
          if (ar_hs) arvalid_r <= 1'b0;
          if (r_hs) begin
            if ((m_axi.rdata != r_exp) || m_axi.rresp[1]) error_r <= 1'b1;
            if (m_axi.rlast) begin
              if (r_idx != LAST_IDX) error_r <= 1'b1;
              rready_r   <= 1'b0;
              arvalid_r  <= 1'b0;
              txn_done_r <= 1'b1;
              state      <= ST_DONE;
            end else if (r_idx == LAST_IDX) begin
              // Final beat without RLAST: flag it and keep draining with the index pinned.
              error_r <= 1'b1;
            end else begin
              r_idx <= r_idx + 8'd1;
              r_exp <= r_exp + ONE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxi_full_burst_master.sv
module tb_maxi_full_burst_master;
  localparam int          LEN  = 4;
  localparam logic [31:0] SEED = 32'h55;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic init  = 1'b0;
  logic txn_done;
  logic error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maxi_full_burst_master_if #(.ID_WIDTH(1), .ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  maxi_full_burst_master #(
    .C_M_AXI_ID_WIDTH(1),
    .C_M_AXI_ADDR_WIDTH(6),
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_BURST_LEN(LEN),
    .C_M_TARGET_BASE_ADDR(32'h0),
    .C_M_DATA_SEED(SEED)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .INIT_AXI_TXN(init),
    .TXN_DONE(txn_done),
    .ERROR(error),
    .m_axi(bus)
  );

  // Scenario record: responder behaviour plus expected outcome.
  typedef struct {
    int          aw_delay;
    int          stall_beat;
    int          stall_cycles;
    logic [1:0]  bresp;
    int          corrupt_beat;
    logic [31:0] corrupt_val;
    int          early_beat;
    int          rresp_beat;
    bit          rand_ready;
    bit          exp_error;
    int          exp_w;
    int          exp_r;
  } vec_t;

  function automatic vec_t mk(int awd, int sb, int sc, logic [1:0] br, int cb, logic [31:0] cv,
                              int eb, int rb, bit rr, bit ee, int ew, int er);
    vec_t v;
    v.aw_delay = awd; v.stall_beat = sb; v.stall_cycles = sc; v.bresp = br;
    v.corrupt_beat = cb; v.corrupt_val = cv; v.early_beat = eb; v.rresp_beat = rb;
    v.rand_ready = rr; v.exp_error = ee; v.exp_w = ew; v.exp_r = er;
    return v;
  endfunction

  // Outcome from the burst rules: read beats delivered, and whether anything is wrong.
  function automatic int model_beats(vec_t v);
    if (v.early_beat >= 0 && v.early_beat < LEN - 1) return v.early_beat + 1;
    return LEN;
  endfunction

  function automatic bit model_error(vec_t v);
    int beats = model_beats(v);
    bit e = v.bresp[1];
    logic [31:0] want;
    logic [31:0] got;
    if (beats != LEN) e = 1'b1;
    for (int i = 0; i < beats; i++) begin
      want = SEED + 32'(i);
      got  = (i == v.corrupt_beat) ? v.corrupt_val : want;
      if (got != want) e = 1'b1;
      if (i == v.rresp_beat) e = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- responder (slave) model ----------------
  vec_t        cfg;
  int          aw_cnt, w_cnt, ar_cnt, r_cnt, aw_wait, stall_left, r_beat;
  bit          aw_seen, b_done, r_active;
  logic        rready_after_last;
  logic [31:0] mem [16];
  logic [31:0] w_data_log [16];
  logic        w_last_log [16];
  logic        p_awvalid, p_awready, p_wvalid, p_wready, p_wlast, p_bvalid, p_bready;
  logic        p_arvalid, p_arready, p_rvalid, p_rready, p_rlast, p_rst_n;
  logic [31:0] p_wdata;

  function automatic bit rnd_ok();
    return !cfg.rand_ready || ($urandom_range(0, 3) != 0);
  endfunction

  task automatic resp_reset(input vec_t v);
    cfg = v;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; aw_wait = 0; r_beat = 0;
    stall_left = v.stall_cycles;
    aw_seen = 0; b_done = 0; r_active = 0;
    rready_after_last = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0; w_data_log[i] = '0; w_last_log[i] = 1'b0;
    end
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.bid = '0;
    bus.arready = 1'b0;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rid = '0;
    p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_wlast = 0; p_wdata = '0;
    p_bvalid = 0; p_bready = 0; p_arvalid = 0; p_arready = 0;
    p_rvalid = 0; p_rready = 0; p_rlast = 0; p_rst_n = 0;
  endtask

  // Runs at each falling edge: account handshakes of the rising edge just passed,
  // check stall stability, then choose slave outputs for the next rising edge.
  task automatic resp_update();
    bit aw_h, w_h, b_h, ar_h, r_h;
    aw_h = p_awvalid && p_awready;
    w_h  = p_wvalid  && p_wready;
    b_h  = p_bvalid  && p_bready;
    ar_h = p_arvalid && p_arready;
    r_h  = p_rvalid  && p_rready;

    if (aw_h) begin aw_cnt++; aw_seen = 1; end
    if (w_h) begin
      if (w_cnt < 16) begin
        mem[w_cnt] = p_wdata; w_data_log[w_cnt] = p_wdata; w_last_log[w_cnt] = p_wlast;
      end
      w_cnt++;
    end
    if (b_h) begin bus.bvalid = 1'b0; b_done = 1; end
    if (ar_h) begin ar_cnt++; r_active = 1; r_beat = 0; end
    if (r_h) begin
      r_cnt++; r_beat++;
      if (p_rlast) begin r_active = 0; rready_after_last = bus.rready; end
    end

    if (rst_n && p_rst_n) begin
      if (p_awvalid && !p_awready) chk("aw_hold", bus.awvalid, 1);
      if (p_wvalid && !p_wready)
        chk("w_hold", {bus.wvalid, bus.wlast, bus.wdata}, {1'b1, p_wlast, p_wdata});
      if (bus.arvalid === 1'b1) chk("rready_with_ar", bus.rready, 1);
    end

    if (bus.awvalid === 1'b1 && !aw_seen) begin
      bus.awready = (aw_wait >= cfg.aw_delay) && rnd_ok();
      aw_wait++;
    end else begin
      bus.awready = 1'b0;
    end

    if (bus.wvalid === 1'b1 && w_cnt == cfg.stall_beat && stall_left > 0) begin
      bus.wready = 1'b0;
      stall_left--;
    end else begin
      bus.wready = rnd_ok();
    end

    if (!bus.bvalid && !b_done && aw_seen && w_cnt >= LEN) begin
      bus.bvalid = 1'b1;
      bus.bresp  = cfg.bresp;
    end

    bus.arready = (bus.arvalid === 1'b1) && rnd_ok();

    if (bus.rvalid && !r_h) begin
      // hold the pending beat
    end else if (r_active && rnd_ok()) begin
      bus.rvalid = 1'b1;
      bus.rdata  = (r_beat == cfg.corrupt_beat) ? cfg.corrupt_val : mem[r_beat];
      bus.rresp  = (r_beat == cfg.rresp_beat) ? 2'b10 : 2'b00;
      bus.rlast  = (r_beat == LEN - 1) || (r_beat == cfg.early_beat);
    end else begin
      bus.rvalid = 1'b0;
    end

    p_awvalid = bus.awvalid; p_awready = bus.awready;
    p_wvalid  = bus.wvalid;  p_wready  = bus.wready; p_wlast = bus.wlast; p_wdata = bus.wdata;
    p_bvalid  = bus.bvalid;  p_bready  = bus.bready;
    p_arvalid = bus.arvalid; p_arready = bus.arready;
    p_rvalid  = bus.rvalid;  p_rready  = bus.rready; p_rlast = bus.rlast;
    p_rst_n   = rst_n;
  endtask

  task automatic tick();
    @(negedge clk);
    resp_update();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " valids/readies"},
        {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.arvalid, bus.rready}, 6'b0);
    chk({tag, " txn_done"}, txn_done, 0);
    chk({tag, " error"}, error, 0);
    chk({tag, " wdata"}, bus.wdata, SEED);
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (txn_done !== 1'b1 && n < 400) begin tick(); n++; end
    chk({tag, " done"}, txn_done, 1);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n;
    resp_reset(v);
    tick();
    pulse_init();
    n = 0;
    while (bus.awvalid !== 1'b1 && n < 10) begin tick(); n++; end
    chk({tag, " start_awvalid"}, bus.awvalid, 1);
    chk({tag, " start_clears_done"}, txn_done, 0);
    chk({tag, " start_clears_error"}, error, 0);
    wait_done(tag);
    chk({tag, " error"}, error, v.exp_error);
    chk({tag, " aw_count"}, aw_cnt, 1);
    chk({tag, " w_count"}, w_cnt, v.exp_w);
    chk({tag, " ar_count"}, ar_cnt, 1);
    chk({tag, " r_count"}, r_cnt, v.exp_r);
    for (int i = 0; i < v.exp_w && i < 16; i++)
      chk($sformatf("%s wbeat%0d", tag, i), {w_last_log[i], w_data_log[i]},
          {(i == LEN - 1), SEED + 32'(i)});
    if (v.early_beat >= 0 && v.early_beat < LEN - 1)
      chk({tag, " rready_drop"}, rready_after_last, 0);
    repeat (3) tick();
    chk({tag, " done_holds"}, {txn_done, error}, {1'b1, v.exp_error});
  endtask

  vec_t vecs [9];
  vec_t v;

  initial begin
    vecs[0] = mk(0, -1, 0, 2'b00, -1, 32'h0,  -1, -1, 0, 0, 4, 4); // clean
    vecs[1] = mk(5,  1, 2, 2'b00, -1, 32'h0,  -1, -1, 0, 0, 4, 4); // W stall + late AW
    vecs[2] = mk(0, -1, 0, 2'b10, -1, 32'h0,  -1, -1, 0, 1, 4, 4); // SLVERR on B
    vecs[3] = mk(0, -1, 0, 2'b00,  2, 32'hFF, -1, -1, 0, 1, 4, 4); // corrupt beat 2
    vecs[4] = mk(0, -1, 0, 2'b00, -1, 32'h0,   1, -1, 0, 1, 4, 2); // RLAST on beat 1
    vecs[5] = mk(2,  0, 1, 2'b00, -1, 32'h0,  -1, -1, 0, 0, 4, 4); // clean after failure
    vecs[6] = mk(0, -1, 0, 2'b00, -1, 32'h0,  -1,  3, 0, 1, 4, 4); // RRESP error last beat
    vecs[7] = mk(0, -1, 0, 2'b01, -1, 32'h0,  -1, -1, 0, 0, 4, 4); // BRESP[1]=0
    vecs[8] = mk(0, -1, 0, 2'b00,  0, 32'h55, -1, -1, 0, 0, 4, 4); // "corrupt" with same value

    resp_reset(mk(0, -1, 0, 2'b00, -1, 0, -1, -1, 0, 0, 4, 4));
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    chk("static awaddr/len/size/burst", {bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
        {6'd0, 8'd3, 3'd2, 2'b01});
    chk("static araddr/len/size/burst", {bus.araddr, bus.arlen, bus.arsize, bus.arburst},
        {6'd0, 8'd3, 3'd2, 2'b01});
    chk("static aw attrs", {bus.awid, bus.awlock, bus.awcache, bus.awprot, bus.awqos, bus.awregion},
        {1'b0, 1'b0, 4'b0010, 3'd0, 4'd0, 4'd0});
    chk("static ar attrs", {bus.arid, bus.arlock, bus.arcache, bus.arprot, bus.arqos, bus.arregion},
        {1'b0, 1'b0, 4'b0010, 3'd0, 4'd0, 4'd0});
    chk("static wstrb", bus.wstrb, 4'hF);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle no start", {bus.awvalid, bus.wvalid}, 2'b00);

    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Start edge while WRITE is in progress must be ignored.
    v = mk(8, -1, 0, 2'b00, -1, 32'h0, -1, -1, 0, 0, 4, 4);
    resp_reset(v);
    tick();
    pulse_init();
    tick();
    chk("busy in write", bus.awvalid, 1);
    pulse_init();
    wait_done("init_in_write");
    chk("init_in_write aw_count", aw_cnt, 1);
    chk("init_in_write w_count", w_cnt, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("init_in_write wbeat%0d", i), w_data_log[i], SEED + 32'(i));
    chk("init_in_write error", error, 0);

    // Randomised handshakes and faults against the rule-based model.
    for (int r = 0; r < 12; r++) begin
      int f;
      v = mk($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), 2'b00,
             -1, 32'h0, -1, -1, 1, 0, LEN, LEN);
      f = $urandom_range(0, 5);
      if (f == 3) v.bresp = 2'($urandom_range(1, 3));
      if (f == 4) begin v.corrupt_beat = $urandom_range(0, 3); v.corrupt_val = $urandom(); end
      if (f == 5) v.early_beat = $urandom_range(0, 2);
      v.exp_error = model_error(v);
      v.exp_r = model_beats(v);
      run_txn(v, $sformatf("rand%0d", r));
    end

    // Reset in the middle of WRITE: outputs return to reset values, nothing resumes.
    v = mk(20, 1, 10, 2'b00, -1, 32'h0, -1, -1, 0, 0, 4, 4);
    resp_reset(v);
    tick();
    pulse_init();
    repeat (3) tick();
    chk("pre-reset in write", bus.awvalid, 1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    resp_reset(mk(0, -1, 0, 2'b00, -1, 32'h0, -1, -1, 0, 0, 4, 4));
    repeat (8) tick();
    chk("no resume", {bus.awvalid, bus.wvalid, 32'(aw_cnt), 32'(w_cnt)}, 66'd0);
    run_txn(vecs[0], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
